gate_stimulus_sequencer: RTL and testbench

- Drives the two input operands of a 2-input logic gate demo through all four input combinations (00, 01, 10, 11).
- At each combination it samples the gate's returned output and checks it against the expected AND result.
- Reports the operands, the observed output, and a PASS/FAIL/DONE verdict on Basys 3 LEDs.
- It is the stimulus/checker end of the switch-in/LED-out gate demos: it generates the inputs the user otherwise sets on switches.

---
 rtl/gate_demo_pkg.sv | 8 +
 rtl/button_debouncer.sv | 37 +++
 rtl/gate_stimulus_sequencer.sv | 111 +++++++++++
 tb/tb_gate_stimulus_sequencer.sv | 113 +++++++++++
 4 files changed

// File: rtl/gate_demo_pkg.sv
// gate_demo_pkg: shared states, vector count and reference gate function for the gate demo sequencer
package gate_demo_pkg;
  localparam int NUM_VECTORS = 4;
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, WAIT, DONE} state_t;
  function automatic logic expected_y(input logic a, input logic b);
    return a & b;
  endfunction
endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: synchronises a bouncy button, accepts a level after DEB_CYCLES stable samples, pulses on rise
module button_debouncer #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic I_P_CLK,
  input  logic I_P_RST,
  input  logic I_P_BTN,
  output logic O_P_LEVEL,
  output logic O_P_PULSE
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d, pulse_q, hit;
  // a differing sample run of DEB_CYCLES flips the accepted level; any agreeing sample restarts the run
  always_comb begin
    hit = (sync_q[1] != level_q) && (cnt_q == CW'(DEB_CYCLES - 1));
    cnt_d = (sync_q[1] == level_q || hit) ? '0 : cnt_q + 1'b1;
    level_d = hit ? sync_q[1] : level_q;
  end
  // synchroniser, stable counter, accepted level and one-cycle rising pulse
  always_ff @(posedge I_P_CLK) begin
    if (I_P_RST) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], I_P_BTN};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= hit & sync_q[1];
    end
  end
  assign O_P_LEVEL = level_q;
  assign O_P_PULSE = pulse_q;
endmodule

// File: rtl/gate_stimulus_sequencer.sv
// gate_stimulus_sequencer: walks a 2-input gate through 00..11, checks each output against AND, shows verdict on LEDs
module gate_stimulus_sequencer
  import gate_demo_pkg::*;
#(
  parameter int CLK_HZ        = 100_000_000,
  parameter int STEP_HZ       = 1,
  parameter int SETTLE_CYCLES = 4,
  parameter int DEB_CYCLES    = 1_000_000
) (
  input  logic I_P_CLK,
  input  logic I_P_RST,
  input  logic I_P_RUN,
  input  logic I_P_STEP,
  input  logic I_P_GATE_Y,
  output logic O_P_A,
  output logic O_P_B,
  output logic O_P_LED_A,
  output logic O_P_LED_B,
  output logic O_P_LED_GATE,
  output logic O_P_LED_PASS,
  output logic O_P_LED_FAIL,
  output logic O_P_LED_DONE
);
  localparam int TICK_DIV = CLK_HZ / STEP_HZ;
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  state_t        state_q, state_d;
  logic [1:0]    run_sync_q, y_sync_q, idx_q, idx_d;
  logic [TW-1:0] tick_cnt_q;
  logic [SW-1:0] settle_q, settle_d;
  logic          a_q, a_d, b_q, b_d, gate_q, gate_d, fail_q, fail_d;
  logic          run_s, y_s, tick, step_pulse, advance, step_level_unused;
  assign run_s   = run_sync_q[1];
  assign y_s     = y_sync_q[1];
  assign tick    = run_s && (tick_cnt_q == TW'(TICK_DIV - 1));
  assign advance = run_s ? tick : step_pulse;
  button_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_step (
    .I_P_CLK  (I_P_CLK),
    .I_P_RST  (I_P_RST),
    .I_P_BTN  (I_P_STEP),
    .O_P_LEVEL(step_level_unused),
    .O_P_PULSE(step_pulse)
  );
  // synchronisers and the tick divider, held at zero while auto-run is off so it restarts on RUN rise
  always_ff @(posedge I_P_CLK) begin
    if (I_P_RST) begin
      run_sync_q <= '0;
      y_sync_q   <= '0;
      tick_cnt_q <= '0;
    end else begin
      run_sync_q <= {run_sync_q[0], I_P_RUN};
      y_sync_q   <= {y_sync_q[0], I_P_GATE_Y};
      tick_cnt_q <= (!run_s || tick) ? '0 : tick_cnt_q + 1'b1;
    end
  end
  // next state; operands are loaded on every entry to DRIVE so they change one cycle after the advance
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    a_d      = a_q;
    b_d      = b_q;
    gate_d   = gate_q;
    fail_d   = fail_q;
    case (state_q)
      IDLE:   if (advance) begin state_d = DRIVE; idx_d = '0; end
      DRIVE:  begin state_d = SETTLE; settle_d = '0; end
      SETTLE: begin
        settle_d = settle_q + 1'b1;
        state_d  = (settle_q == SW'(SETTLE_CYCLES - 1)) ? CHECK : SETTLE;
      end
      CHECK:  begin
        gate_d  = y_s;
        fail_d  = fail_q | (y_s != expected_y(idx_q[1], idx_q[0]));
        state_d = (idx_q == 2'(NUM_VECTORS - 1)) ? DONE : WAIT;
      end
      WAIT:   if (advance) begin state_d = DRIVE; idx_d = idx_q + 2'd1; end
      DONE:   if (step_pulse) begin state_d = DRIVE; idx_d = '0; fail_d = 1'b0; end
      default: state_d = IDLE;
    endcase
    if (state_d == DRIVE && state_q != DRIVE) {a_d, b_d} = idx_d;
  end
  // sequencer state and registered outputs
  always_ff @(posedge I_P_CLK) begin
    if (I_P_RST) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      gate_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      a_q      <= a_d;
      b_q      <= b_d;
      gate_q   <= gate_d;
      fail_q   <= fail_d;
    end
  end
  assign O_P_A        = a_q;
  assign O_P_B        = b_q;
  assign O_P_LED_A    = a_q;
  assign O_P_LED_B    = b_q;
  assign O_P_LED_GATE = gate_q;
  assign O_P_LED_FAIL = fail_q;
  assign O_P_LED_DONE = (state_q == DONE);
  assign O_P_LED_PASS = (state_q == DONE) && !fail_q;
endmodule

// File: tb/tb_gate_stimulus_sequencer.sv
// tb_gate_stimulus_sequencer: directed checks of auto-run, step mode, debounce, failure flag and reset
module tb_gate_stimulus_sequencer;
  logic clk = 1'b0, rst = 1'b1, run = 1'b0, step = 1'b0, gate_y = 1'b0, or_mode = 1'b0;
  logic a, b, la, lb, lg, lp, lf, ld;
  logic [7:0] outs;
  int n_run = 0, n_fail = 0, cyc = 0, t1 = 0, t2 = 0, t3 = 0;
  assign outs = {a, b, la, lb, lg, lp, lf, ld};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) gate_y <= or_mode ? (a | b) : (a & b);
  gate_stimulus_sequencer #(
    .CLK_HZ(64), .STEP_HZ(1), .SETTLE_CYCLES(32), .DEB_CYCLES(8)
  ) dut (
    .I_P_CLK(clk), .I_P_RST(rst), .I_P_RUN(run), .I_P_STEP(step), .I_P_GATE_Y(gate_y),
    .O_P_A(a), .O_P_B(b), .O_P_LED_A(la), .O_P_LED_B(lb), .O_P_LED_GATE(lg),
    .O_P_LED_PASS(lp), .O_P_LED_FAIL(lf), .O_P_LED_DONE(ld)
  );
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_ab(input string tag, input logic [1:0] v, output int t);
    int k = 0;
    while ({a, b} !== v && k < 400) begin @(negedge clk); k++; end
    t = cyc;
    check(tag, {6'b0, a, b}, {6'b0, v});
  endtask
  task automatic wait_done(input string tag, input logic [7:0] exp);
    int k = 0;
    while (ld !== 1'b1 && k < 400) begin @(negedge clk); k++; end
    check(tag, outs, exp);
  endtask
  task automatic press(input int bounce);
    for (int i = 0; i < bounce; i++) begin step = ~step; cycles(1); end
    step = 1'b1;
    cycles(20);
    step = 1'b0;
    cycles(40);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
  endtask
  initial begin
    cycles(3);
    rst = 1'b0;
    cycles(100);
    check("idle_after_reset", outs, 8'b0000_0000);
    press(0);
    check("step_vec00", outs, 8'b0000_0000);
    press(5);
    check("bounce_one_advance", outs, 8'b0101_0000);
    press(0);
    check("step_vec10", outs, 8'b1010_0000);
    press(0);
    check("step_done", outs, 8'b1111_1101);
    press(0);
    check("restart_vec00", outs, 8'b0000_0000);
    step = 1'b1;
    wait_ab("step_to_01", 2'b01, t1);
    step = 1'b0;
    cycles(12);
    step = 1'b1;
    cycles(15);
    step = 1'b0;
    cycles(60);
    check("settle_step_ignored", outs, 8'b0101_0000);
    press(0);
    check("next_after_ignore", outs, 8'b1010_0000);
    cycles(200);
    check("run0_no_tick", outs, 8'b1010_0000);
    do_reset();
    run = 1'b1;
    wait_ab("and_v01", 2'b01, t1);
    wait_ab("and_v10", 2'b10, t2);
    check("tick_gap_01_10", 8'(t2 - t1), 8'd64);
    wait_ab("and_v11", 2'b11, t3);
    check("tick_gap_10_11", 8'(t3 - t2), 8'd64);
    wait_done("and_done", 8'b1111_1101);
    cycles(150);
    check("done_hold", outs, 8'b1111_1101);
    do_reset();
    or_mode = 1'b1;
    wait_ab("or_v01", 2'b01, t1);
    cycles(1);
    check("or_no_fail_at_00", outs, 8'b0101_0000);
    cycles(40);
    check("or_fail_at_01", outs, 8'b0101_1010);
    wait_done("or_done", 8'b1111_1011);
    do_reset();
    wait_ab("rst_v10", 2'b10, t1);
    cycles(5);
    check("pre_reset_settle10", outs, 8'b1010_1010);
    rst = 1'b1;
    cycles(1);
    check("reset_mid_settle", outs, 8'b0000_0000);
    rst = 1'b0;
    or_mode = 1'b0;
    wait_ab("restart_v01", 2'b01, t1);
    wait_ab("restart_v10", 2'b10, t2);
    wait_ab("restart_v11", 2'b11, t3);
    wait_done("restart_done", 8'b1111_1101);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
